// File: rtl/sweep_pkg.sv
// Shared types and widths for the truth-table sweeper.
package sweep_pkg;

   // Sweep controller states
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DRIVE  = 2'd1,
      SAMPLE = 2'd2,
      RESULT = 2'd3
   } sweep_state_e;

   // Width of the settle down-counter; covers SETTLE_CYCLES up to 255
   localparam int unsigned SETTLE_W = 8;

endpackage : sweep_pkg

// File: rtl/settle_timer.sv
// Loadable down-counter that measures how long a vector is held before sampling.
module settle_timer
   import sweep_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                load_i,
   input  logic [SETTLE_W-1:0] load_val_i,
   input  logic                en_i,
   output logic                done_c
);

   logic [SETTLE_W-1:0] cnt_q;
   logic [SETTLE_W-1:0] cnt_d;

   // Next count: load wins, otherwise count down and stop at zero
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (en_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - SETTLE_W'(1);
      end
   end

   // Counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done_c = (cnt_q == '0);

endmodule : settle_timer

// File: rtl/truth_table_sweeper.sv
// Drives every input vector into a combinational cone, samples its output,
// builds the truth table and compares it with an expected table.
// Optional macro SWEEP_GRAY_EN: sweep vectors in Gray-code order instead of
// binary order; the table is still indexed by vector value.
module truth_table_sweeper
   import sweep_pkg::*;
#(
   parameter int unsigned N_IN          = 2,
   parameter int unsigned SETTLE_CYCLES = 1
)
(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start_i,
   input  logic [(1<<N_IN)-1:0]   expected_i,
   output logic [N_IN-1:0]        x_o,
   input  logic                   z_i,
   output logic                   busy_o,
   output logic [(1<<N_IN)-1:0]   table_o,
   output logic                   mismatch_o,
   output logic                   done_valid_o,
   input  logic                   done_ready_i
);

   localparam int unsigned TW          = 1 << N_IN;
   localparam int unsigned IDX_W       = N_IN + 1;
   localparam int unsigned SETTLE_LOAD = (SETTLE_CYCLES > 0) ? (SETTLE_CYCLES - 1) : 0;
   localparam bit          HAS_SETTLE  = (SETTLE_CYCLES > 0);

   sweep_state_e     state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [N_IN-1:0]  x_q, x_d;
   logic [TW-1:0]    table_q, table_d;
   logic [TW-1:0]    exp_q, exp_d;
   logic             mismatch_q, mismatch_d;
   logic             done_q, done_d;
   logic             busy_q, busy_d;

   logic             tmr_load_c;
   logic             tmr_en_c;
   logic             tmr_done_c;
   logic [IDX_W-1:0] idx_nxt_c;

   // Map sweep position to the vector value driven on x_o
   function automatic logic [N_IN-1:0] vec_of(input logic [IDX_W-1:0] i);
`ifdef SWEEP_GRAY_EN
      return N_IN'(i ^ (i >> 1));
`else
      return N_IN'(i);
`endif
   endfunction

   // Hold time per vector before its sample cycle
   settle_timer u_settle_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (tmr_load_c),
      .load_val_i (SETTLE_W'(SETTLE_LOAD)),
      .en_i       (tmr_en_c),
      .done_c     (tmr_done_c)
   );

   assign idx_nxt_c = idx_q + IDX_W'(1);

   // Next-state, datapath and output computation for the sweep FSM
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      x_d        = x_q;
      table_d    = table_q;
      exp_d      = exp_q;
      mismatch_d = mismatch_q;
      done_d     = done_q;
      tmr_load_c = 1'b0;
      tmr_en_c   = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               exp_d      = expected_i;
               idx_d      = '0;
               table_d    = '0;
               x_d        = vec_of('0);
               tmr_load_c = HAS_SETTLE;
               state_d    = HAS_SETTLE ? DRIVE : SAMPLE;
            end
         end

         DRIVE: begin
            tmr_en_c = 1'b1;
            if (tmr_done_c) begin
               state_d = SAMPLE;
            end
         end

         SAMPLE: begin
            table_d[vec_of(idx_q)] = z_i;
            if (idx_q == IDX_W'(TW - 1)) begin
               // Result is registered on the edge that enters RESULT
               x_d        = '0;
               mismatch_d = (table_d != exp_q);
               done_d     = 1'b1;
               state_d    = RESULT;
            end else begin
               idx_d      = idx_nxt_c;
               x_d        = vec_of(idx_nxt_c);
               tmr_load_c = HAS_SETTLE;
               state_d    = HAS_SETTLE ? DRIVE : SAMPLE;
            end
         end

         RESULT: begin
            if (done_ready_i) begin
               done_d  = 1'b0;
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   // State and output registers; reset aborts any sweep in progress
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         x_q        <= '0;
         table_q    <= '0;
         exp_q      <= '0;
         mismatch_q <= 1'b0;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         x_q        <= x_d;
         table_q    <= table_d;
         exp_q      <= exp_d;
         mismatch_q <= mismatch_d;
         done_q     <= done_d;
         busy_q     <= busy_d;
      end
   end

   assign x_o          = x_q;
   assign table_o      = table_q;
   assign mismatch_o   = mismatch_q;
   assign done_valid_o = done_q;
   assign busy_o       = busy_q;

endmodule : truth_table_sweeper

// File: tb/tb_truth_table_sweeper.sv
// Self-checking bench for truth_table_sweeper: one instance with one settle
// cycle, one with none, both driving a table-defined cone.
module tb_truth_table_sweeper;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic [3:0] cone_tt;

   // Instance A: SETTLE_CYCLES = 1
   logic       a_start, a_z, a_busy, a_mm, a_dv, a_rdy;
   logic [3:0] a_exp, a_tab;
   logic [1:0] a_x;
   // Instance B: SETTLE_CYCLES = 0
   logic       b_start, b_z, b_busy, b_mm, b_dv, b_rdy;
   logic [3:0] b_exp, b_tab;
   logic [1:0] b_x;

   int n_cmp = 0;
   int n_bad = 0;

   // Cone model: output is the truth-table bit addressed by the vector
   assign a_z = cone_tt[a_x];
   assign b_z = cone_tt[b_x];

   truth_table_sweeper #(.N_IN(2), .SETTLE_CYCLES(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .start_i(a_start), .expected_i(a_exp),
      .x_o(a_x), .z_i(a_z), .busy_o(a_busy), .table_o(a_tab),
      .mismatch_o(a_mm), .done_valid_o(a_dv), .done_ready_i(a_rdy));

   truth_table_sweeper #(.N_IN(2), .SETTLE_CYCLES(0)) dut_b (
      .clk(clk), .rst_n(rst_n), .start_i(b_start), .expected_i(b_exp),
      .x_o(b_x), .z_i(b_z), .busy_o(b_busy), .table_o(b_tab),
      .mismatch_o(b_mm), .done_valid_o(b_dv), .done_ready_i(b_rdy));

   // Sweep order: k-th vector value
   function automatic int vm(input int k);
`ifdef SWEEP_GRAY_EN
      return k ^ (k >> 1);
`else
      return k;
`endif
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Full sweep on one instance, checked cycle by cycle against the model
   task automatic sweep(input bit use_b, input logic [3:0] exp_tab, input bit hold, input string tag);
      int         cpv;
      int         len;
      logic [3:0] want_tab;
      logic       want_mm;
      logic [1:0] ox;
      logic [3:0] ot;
      logic       omm, odv, obusy;
      cpv      = use_b ? 1 : 2;
      len      = 4 * cpv;
      want_tab = cone_tt;
      want_mm  = (cone_tt != exp_tab);
      if (use_b) begin
         b_rdy = !hold; b_start = 1'b1; b_exp = exp_tab;
      end else begin
         a_rdy = !hold; a_start = 1'b1; a_exp = exp_tab;
      end
      step();
      a_start = 1'b0; b_start = 1'b0;
      a_exp = 4'($urandom); b_exp = 4'($urandom);
      for (int j = 0; j < len; j++) begin
         ox = use_b ? b_x : a_x; odv = use_b ? b_dv : a_dv; obusy = use_b ? b_busy : a_busy;
         n_cmp++;
         if (ox !== 2'(vm(j / cpv))) begin
            n_bad++; $display("FAIL %s x_o step %0d: got %0d want %0d", tag, j, ox, vm(j / cpv));
         end
         n_cmp++;
         if (odv !== 1'b0 || obusy !== 1'b1) begin
            n_bad++; $display("FAIL %s early_valid step %0d: dv=%b busy=%b want dv=0 busy=1", tag, j, odv, obusy);
         end
         step();
      end
      ox = use_b ? b_x : a_x; ot = use_b ? b_tab : a_tab; omm = use_b ? b_mm : a_mm;
      odv = use_b ? b_dv : a_dv;
      n_cmp++;
      if (odv !== 1'b1) begin
         n_bad++; $display("FAIL %s latency: done_valid=%b want 1 after %0d cycles", tag, odv, len);
      end
      n_cmp++;
      if (ot !== want_tab) begin
         n_bad++; $display("FAIL %s table: got %b want %b", tag, ot, want_tab);
      end
      n_cmp++;
      if (omm !== want_mm) begin
         n_bad++; $display("FAIL %s mismatch: got %b want %b", tag, omm, want_mm);
      end
      n_cmp++;
      if (ox !== 2'd0) begin
         n_bad++; $display("FAIL %s x_o_result: got %0d want 0", tag, ox);
      end
      if (hold) begin
         for (int h = 0; h < 5; h++) begin
            if (use_b) b_start = h[0]; else a_start = h[0];
            if (use_b) b_exp = ~exp_tab; else a_exp = ~exp_tab;
            step();
            ot = use_b ? b_tab : a_tab; odv = use_b ? b_dv : a_dv; omm = use_b ? b_mm : a_mm;
            n_cmp++;
            if (odv !== 1'b1 || ot !== want_tab || omm !== want_mm) begin
               n_bad++;
               $display("FAIL %s hold %0d: dv=%b tab=%b mm=%b want dv=1 tab=%b mm=%b",
                        tag, h, odv, ot, omm, want_tab, want_mm);
            end
         end
         a_start = 1'b0; b_start = 1'b0;
         if (use_b) b_rdy = 1'b1; else a_rdy = 1'b1;
      end
      step();
      odv = use_b ? b_dv : a_dv; obusy = use_b ? b_busy : a_busy;
      n_cmp++;
      if (odv !== 1'b0 || obusy !== 1'b0) begin
         n_bad++; $display("FAIL %s release: dv=%b busy=%b want 0 0", tag, odv, obusy);
      end
      step();
      obusy = use_b ? b_busy : a_busy;
      n_cmp++;
      if (obusy !== 1'b0) begin
         n_bad++; $display("FAIL %s idle_after: busy=%b want 0 (start not queued)", tag, obusy);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) step();
      n_cmp++;
      if ({a_x, a_tab, a_mm, a_dv, a_busy} !== 9'd0) begin
         n_bad++; $display("FAIL reset_a: x=%0d tab=%b mm=%b dv=%b busy=%b want all 0", a_x, a_tab, a_mm, a_dv, a_busy);
      end
      n_cmp++;
      if ({b_x, b_tab, b_mm, b_dv, b_busy} !== 9'd0) begin
         n_bad++; $display("FAIL reset_b: x=%0d tab=%b mm=%b dv=%b busy=%b want all 0", b_x, b_tab, b_mm, b_dv, b_busy);
      end
      @(negedge clk);
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_match();
      cone_tt = 4'b1101;
      sweep(1'b0, 4'b1101, 1'b0, "match");
   endtask

   task automatic test_mismatch();
      cone_tt = 4'b1101;
      sweep(1'b0, 4'b1001, 1'b0, "mismatch");
   endtask

   task automatic test_backpressure();
      cone_tt = 4'b1101;
      sweep(1'b0, 4'b1101, 1'b1, "backpressure");
   endtask

   task automatic test_reset_mid_sweep();
      cone_tt = 4'b1101;
      a_rdy = 1'b1; a_start = 1'b1; a_exp = 4'b1101;
      step();
      a_start = 1'b0;
      repeat (4) step();
      n_cmp++;
      if (a_x !== 2'(vm(2))) begin
         n_bad++; $display("FAIL midreset_pre: x_o=%0d want %0d", a_x, vm(2));
      end
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({a_x, a_tab, a_mm, a_dv, a_busy} !== 9'd0) begin
         n_bad++; $display("FAIL midreset_async: x=%0d tab=%b mm=%b dv=%b busy=%b want all 0", a_x, a_tab, a_mm, a_dv, a_busy);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 10; c++) begin
         step();
         n_cmp++;
         if (a_dv !== 1'b0 || a_busy !== 1'b0) begin
            n_bad++; $display("FAIL midreset_no_result cycle %0d: dv=%b busy=%b want 0 0", c, a_dv, a_busy);
         end
      end
      sweep(1'b0, 4'b1101, 1'b0, "after_reset");
   endtask

   task automatic test_settle_zero();
      cone_tt = 4'b1101;
      sweep(1'b1, 4'b1101, 1'b0, "settle0");
      sweep(1'b1, 4'b0010, 1'b1, "settle0_mm");
   endtask

   task automatic test_random();
      logic [3:0] e;
      for (int it = 0; it < 10; it++) begin
         cone_tt = 4'($urandom);
         e = ($urandom_range(0, 1) == 1) ? cone_tt : 4'($urandom);
         sweep(it[0], e, ($urandom_range(0, 3) == 0), "random");
      end
   endtask

   initial begin
      rst_n   = 1'b0;
      cone_tt = 4'b1101;
      a_start = 1'b0; a_exp = '0; a_rdy = 1'b1;
      b_start = 1'b0; b_exp = '0; b_rdy = 1'b1;
      test_reset();
      test_match();
      test_mismatch();
      test_backpressure();
      test_reset_mid_sweep();
      test_settle_zero();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_truth_table_sweeper
